// File: rtl/three_input_demorgan_type_1_a_pkg.sv
// Shared constants for the three-input De Morgan equivalence block:
// default operand width and the register reset values.
package three_input_demorgan_type_1_a_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int MAX_WIDTH     = 64;

    // Results reset to all-ones, matching what the block yields for all-zero inputs.
    localparam logic [MAX_WIDTH-1:0] RESULT_RST   = {MAX_WIDTH{1'b1}};
    localparam logic                 MISMATCH_RST = 1'b0;

endpackage

// File: rtl/three_input_demorgan_type_1_a_demorgan_lane.sv
// One bit lane: the NAND form and the complement-OR form of the same
// function, built as two deliberately separate logic cones.
module demorgan_lane
    import three_input_demorgan_type_1_a_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    output logic nand_out,
    output logic alt_out
);

    logic and_term;
    logic a_n;
    logic b_n;
    logic c_n;

    // AND-then-invert path.
    assign and_term = a & b & c;
    assign nand_out = ~and_term;

    // Invert-then-OR path; shares no gates with the path above.
    assign a_n     = ~a;
    assign b_n     = ~b;
    assign c_n     = ~c;
    assign alt_out = a_n | b_n | c_n;

endmodule

// File: rtl/three_input_demorgan_type_1_a.sv
// Registers both De Morgan forms per lane and raises a sticky flag if the
// two registered results ever disagree in any bit.
module three_input_demorgan_type_1_a
    import three_input_demorgan_type_1_a_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] d_alt,
    output logic             mismatch
);

    logic [WIDTH-1:0] lane_nand;
    logic [WIDTH-1:0] lane_alt;

    for (genvar i = 0; i < WIDTH; i++) begin : gen_lane
        demorgan_lane u_lane (
            .a        (a[i]),
            .b        (b[i]),
            .c        (c[i]),
            .nand_out (lane_nand[i]),
            .alt_out  (lane_alt[i])
        );
    end

    // The flag compares the registered results, so it trails a disagreement by one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d        <= RESULT_RST[WIDTH-1:0];
            d_alt    <= RESULT_RST[WIDTH-1:0];
            mismatch <= MISMATCH_RST;
        end else begin
            d     <= lane_nand;
            d_alt <= lane_alt;
            if (d != d_alt) begin
                mismatch <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_three_input_demorgan_type_1_a.sv
// Randomized and directed checks of the De Morgan block against a
// per-bit "all three ones" reference model.
module tb_three_input_demorgan_type_1_a;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] d;
    logic [W-1:0] d_alt;
    logic         mismatch;

    int total = 0;
    int bad   = 0;

    three_input_demorgan_type_1_a #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .d_alt    (d_alt),
        .mismatch (mismatch)
    );

    always #5 clk = ~clk;

    // Reference: a result bit is low only when all three operand bits are high.
    function automatic logic [W-1:0] model_result(input logic [W-1:0] ma,
                                                  input logic [W-1:0] mb,
                                                  input logic [W-1:0] mc);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            int ones;
            ones = int'(ma[i]) + int'(mb[i]) + int'(mc[i]);
            r[i] = (ones == 3) ? 1'b0 : 1'b1;
        end
        return r;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] got,
                                input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: drive inputs, let one edge pass, check 1 ns later.
    task automatic apply_stimulus(input string tag, input logic [W-1:0] ta,
                                  input logic [W-1:0] tb, input logic [W-1:0] tc,
                                  input logic exp_mm);
        logic [W-1:0] exp_r;
        a = ta;
        b = tb;
        c = tc;
        exp_r = model_result(ta, tb, tc);
        @(posedge clk);
        #1;
        check_output({tag, "_d"}, 64'(d), 64'(exp_r));
        check_output({tag, "_dalt"}, 64'(d_alt), 64'(exp_r));
        check_output({tag, "_mm"}, 64'(mismatch), 64'(exp_mm));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] ones_v;
        ones_v = {W{1'b1}};

        // Reset holds results at all-ones regardless of inputs or clock.
        rst = 1'b1;
        a = ones_v;
        b = ones_v;
        c = ones_v;
        #1;
        check_output("rst_d", 64'(d), 64'(ones_v));
        check_output("rst_dalt", 64'(d_alt), 64'(ones_v));
        check_output("rst_mm", 64'(mismatch), 64'd0);
        @(posedge clk);
        #1;
        check_output("rst_clk_d", 64'(d), 64'(ones_v));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("rel_hold_d", 64'(d), 64'(ones_v));
        @(posedge clk);
        #1;
        check_output("rel_first_d", 64'(d), 64'd0);
        check_output("rel_first_dalt", 64'(d_alt), 64'd0);
        @(negedge clk);

        // Exhaustive truth table, a as MSB, every lane driven alike.
        for (int k = 0; k < 8; k++) begin
            logic [2:0] combo;
            combo = 3'(k);
            apply_stimulus($sformatf("scan%0d", k), {W{combo[2]}}, {W{combo[1]}},
                           {W{combo[0]}}, 1'b0);
        end

        // Inputs that change just after an edge must wait for the next edge.
        apply_stimulus("lat_111", ones_v, ones_v, ones_v, 1'b0);
        @(posedge clk);
        #1;
        a = '0;
        #2;
        check_output("lat_hold_d", 64'(d), 64'd0);
        @(negedge clk);
        check_output("lat_hold2_d", 64'(d), 64'd0);
        @(posedge clk);
        #1;
        check_output("lat_next_d", 64'(d), 64'(ones_v));
        @(negedge clk);

        apply_stimulus("lanes", 4'hF, 4'hA, 4'hC, 1'b0);
        check_output("lanes_const", 64'(d), 64'h7);

        for (int k = 0; k < 40; k++) begin
            apply_stimulus($sformatf("rnd%0d", k), W'($urandom), W'($urandom),
                           W'($urandom), 1'b0);
        end

        // Fault injection: lane 0 of the complement-OR path stuck low for one edge.
        a = '0;
        b = '0;
        c = '0;
        force dut.lane_alt = 4'b1110;
        @(posedge clk);
        #1;
        check_output("flt_dalt", 64'(d_alt), 64'hE);
        check_output("flt_mm_early", 64'(mismatch), 64'd0);
        @(negedge clk);
        release dut.lane_alt;
        @(posedge clk);
        #1;
        check_output("flt_mm_set", 64'(mismatch), 64'd1);
        check_output("flt_dalt_ok", 64'(d_alt), 64'(ones_v));
        repeat (3) @(posedge clk);
        #1;
        check_output("flt_mm_sticky", 64'(mismatch), 64'd1);

        // Mid-cycle asynchronous reset clears the flag without a clock edge.
        a = ones_v;
        b = ones_v;
        c = ones_v;
        @(posedge clk);
        #1;
        check_output("pre_ar_d", 64'(d), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check_output("ar_d", 64'(d), 64'(ones_v));
        check_output("ar_dalt", 64'(d_alt), 64'(ones_v));
        check_output("ar_mm", 64'(mismatch), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus("post_ar", 4'h3, 4'h5, 4'hF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
